// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment display path.
// BCD widths, limits and the digit-scan state encoding.
package sevseg_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      ON
   } scan_state_e;

endpackage

// File: rtl/bcd_digit_scanner_if.sv
// Bundle between the digit source and the display scanner.
// The master supplies digits and enables, the slave drives the display.
interface bcd_digit_scanner_if #(
   parameter int NUM_DIGITS = 4
);

   logic                                   en;
   logic [sevseg_pkg::BCD_W*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]                  dp_in;
   logic                                   lz_blank;
   logic [sevseg_pkg::BCD_W-1:0]           bcd_out;
   logic                                   dp_out;
   logic [NUM_DIGITS-1:0]                  an_n;
   logic                                   blank_out;
   logic                                   frame_start;

   modport master (
      output en, digits_in, dp_in, lz_blank,
      input  bcd_out, dp_out, an_n, blank_out, frame_start
   );

   modport slave (
      input  en, digits_in, dp_in, lz_blank,
      output bcd_out, dp_out, an_n, blank_out, frame_start
   );

endinterface

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts each digit slot and flags the end of the
// dead time and the end of the slot.
module scan_tick_gen #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic blank_done,
   output logic slot_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0] cnt;

   assign slot_done  = run && (cnt == CW'(REFRESH_DIV - 1));
   assign blank_done = run && (cnt == CW'(BLANK_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !run || slot_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multiplexes snapshotted BCD digits onto one decoder with dead time
// between digits and optional leading-zero blanking.
module bcd_digit_scanner
   import sevseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input logic               clk,
   input logic               rst_n,
   bcd_digit_scanner_if.slave scan
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = BCD_W * NUM_DIGITS;
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

   scan_state_e state, nxt;
   logic [IW-1:0] idx, nidx;
   logic [DW-1:0] snap_d, src_d;
   logic [NUM_DIGITS-1:0] snap_dp, src_dp, zmask, an_q, an_d;
   logic snap_lz, src_lz;
   logic blank_done, slot_done;
   logic fs_q, fs_d, dp_q, dp_d, blk_q, blk_d;
   logic supp_q, supp_d, acc, blank_entry;
   logic [BCD_W-1:0] bcd_q, bcd_d, dig;

   scan_tick_gen #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (!scan.en),
      .run        (state != IDLE),
      .blank_done (blank_done),
      .slot_done  (slot_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= nxt;
         idx   <= nidx;
      end
   end

   always_comb begin
      nxt  = state;
      nidx = idx;
      if (!scan.en) begin
         nxt  = IDLE;
         nidx = '0;
      end else begin
         unique case (state)
            IDLE: begin
               nxt  = BLANK;
               nidx = '0;
            end
            BLANK: if (blank_done) nxt = ON;
            ON: if (slot_done) begin
               nxt  = BLANK;
               nidx = (idx == LAST) ? '0 : idx + 1'b1;
            end
            default: begin
               nxt  = IDLE;
               nidx = '0;
            end
         endcase
      end
   end

   // The slot about to start sees the new snapshot on a frame start.
   always_comb begin
      blank_entry = (nxt == BLANK) && (state != BLANK);
      fs_d   = blank_entry && (nidx == '0);
      src_d  = fs_d ? scan.digits_in : snap_d;
      src_dp = fs_d ? scan.dp_in : snap_dp;
      src_lz = fs_d ? scan.lz_blank : snap_lz;
      acc    = 1'b1;
      zmask  = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         acc      = acc && (src_d[k*BCD_W +: BCD_W] == '0);
         zmask[k] = acc;
      end
      dig    = src_d[nidx*BCD_W +: BCD_W];
      supp_d = supp_q;
      bcd_d  = bcd_q;
      dp_d   = dp_q;
      if (nxt == IDLE) begin
         supp_d = 1'b0;
         bcd_d  = '0;
         dp_d   = 1'b0;
      end else if (blank_entry) begin
         supp_d = (dig > BCD_MAX) ||
                  (src_lz && (nidx != '0) && zmask[nidx]);
         bcd_d  = dig;
         dp_d   = src_dp[nidx] && !supp_d;
      end
      an_d = '1;
      if ((nxt == ON) && !supp_q) an_d[idx] = 1'b0;
      blk_d = (nxt != ON) || supp_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_d  <= '0;
         snap_dp <= '0;
         snap_lz <= 1'b0;
         supp_q  <= 1'b0;
         an_q    <= '1;
         bcd_q   <= '0;
         dp_q    <= 1'b0;
         blk_q   <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         if (fs_d) begin
            snap_d  <= scan.digits_in;
            snap_dp <= scan.dp_in;
            snap_lz <= scan.lz_blank;
         end
         supp_q <= supp_d;
         an_q   <= an_d;
         bcd_q  <= bcd_d;
         dp_q   <= dp_d;
         blk_q  <= blk_d;
         fs_q   <= fs_d;
      end
   end

   assign scan.an_n        = an_q;
   assign scan.bcd_out     = bcd_q;
   assign scan.dp_out      = dp_q;
   assign scan.blank_out   = blk_q;
   assign scan.frame_start = fs_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Bench for bcd_digit_scanner: directed scenarios then random traffic,
// every cycle compared with a time-based reference model.
module tb_bcd_digit_scanner;

   localparam int N  = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   bit   m_run = 0;
   int   m_t = 0;
   int   m_d[N];
   bit   m_dp[N];
   bit   m_lz = 0;

   always #5 clk = ~clk;

   bcd_digit_scanner_if #(.NUM_DIGITS(N)) bus ();

   bcd_digit_scanner #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .scan  (bus.slave)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic take_snap();
      for (int k = 0; k < N; k++) begin
         m_d[k]  = int'(bus.digits_in[4*k +: 4]);
         m_dp[k] = bus.dp_in[k];
      end
      m_lz = bus.lz_blank;
   endtask

   function automatic bit tail_zero(input int s);
      bit z = 1;
      for (int k = s; k < N; k++) if (m_d[k] != 0) z = 0;
      return z;
   endfunction

   // Advance the model by one clock edge using the sampled inputs.
   task automatic model_edge();
      if (!rst_n || !bus.en) begin
         m_run = 0;
      end else if (!m_run) begin
         m_run = 1;
         m_t   = 0;
         take_snap();
      end else begin
         m_t++;
         if (m_t == N * RD) begin
            m_t = 0;
            take_snap();
         end
      end
   endtask

   task automatic check_all();
      int s, ph, d;
      bit supp, on;
      logic [N-1:0] ean;
      chk("onehot", 32'($countones(~bus.an_n) <= 1), 1);
      chk("blank_vs_an", 32'(bus.blank_out), 32'(bus.an_n == '1));
      if (!m_run) begin
         chk("idle_an", bus.an_n, 4'hf);
         chk("idle_blank", bus.blank_out, 1);
         chk("idle_fs", bus.frame_start, 0);
      end else begin
         s    = m_t / RD;
         ph   = m_t % RD;
         d    = m_d[s];
         supp = (d > 9) || (m_lz && s != 0 && tail_zero(s));
         on   = (ph >= BC) && !supp;
         ean  = on ? ~(4'b1 << s) : 4'hf;
         chk("an_n", bus.an_n, ean);
         chk("blank", bus.blank_out, 32'(!on));
         chk("fs", bus.frame_start, 32'(m_t == 0));
         chk("bcd", bus.bcd_out, d);
         chk("dp", bus.dp_out, 32'(m_dp[s] && !supp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int t);
      for (int i = 0; i < 2 * N * RD && m_t != t; i++) step();
   endtask

   initial begin
      bus.en        = 1'b0;
      bus.digits_in = '0;
      bus.dp_in     = '0;
      bus.lz_blank  = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(2);

      // Reset arriving in the middle of an ON phase.
      bus.en        = 1'b1;
      bus.digits_in = 16'h1234;
      bus.dp_in     = 4'b0100;
      run(5);
      rst_n = 1'b0;
      #1;
      chk("rst_an", bus.an_n, 4'hf);
      chk("rst_blank", bus.blank_out, 1);
      chk("rst_bcd", bus.bcd_out, 0);
      chk("rst_fs", bus.frame_start, 0);
      chk("rst_dp", bus.dp_out, 0);
      m_run  = 0;
      bus.en = 1'b0;
      step();
      rst_n = 1'b1;
      run(2);

      bus.en = 1'b1;
      run(2 * N * RD);

      bus.lz_blank  = 1'b1;
      bus.digits_in = 16'h0050;
      run(2 * N * RD);
      bus.digits_in = 16'h0000;
      run(2 * N * RD);

      bus.lz_blank  = 1'b0;
      bus.digits_in = 16'h12A4;
      run(2 * N * RD);

      // Mid-frame input change must wait for the next frame.
      bus.digits_in = 16'h1234;
      run(N * RD);
      run_to(RD + 1);
      bus.digits_in = 16'h5678;
      run(2 * N * RD);

      run_to(2 * RD + 3);
      bus.en = 1'b0;
      run(4);
      bus.en = 1'b1;
      run(N * RD + 4);

      for (int r = 0; r < 80; r++) begin
         for (int k = 0; k < N; k++)
            bus.digits_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ?
               4'd0 : 4'($urandom_range(0, 11));
         bus.dp_in    = N'($urandom);
         bus.lz_blank = 1'($urandom);
         bus.en       = ($urandom_range(0, 9) != 0);
         run($urandom_range(1, 40));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
